dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped DDS frequency sweep controller with dwell timing.
// Define DDS_SWEEP_TRIANGLE_EN for triangle continuous sweeps (default: sawtooth).
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int PW = 12,
    parameter int DW = 16
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [PW-1:0] cfg_pword,
    input  logic          cfg_cont,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] Fword,
    output logic [PW-1:0] Pword,
    output logic          busy,
    output logic          step_stb,
    output logic          done
);
`ifdef DDS_SWEEP_TRIANGLE_EN
    typedef enum logic [1:0] {IDLE, DWELL_UP, DWELL_DN} state_t;
`else
    typedef enum logic {IDLE, DWELL_UP} state_t;
`endif
    state_t state, state_nxt;
    logic [FW-1:0] f_start, f_stop, f_step, fword_nxt, up_word;
    logic [DW-1:0] dwell, cnt, cnt_nxt;
    logic [PW-1:0] pword, pword_nxt;
    logic          cont, stb_nxt, done_nxt, sweep_end;
    logic [FW:0]   up_sum;

    // The extra sum bit catches wrap-around so it saturates instead of restarting low.
    assign up_sum    = {1'b0, Fword} + {1'b0, f_step};
    assign up_word   = (!up_sum[FW] && up_sum[FW-1:0] < f_stop && f_step != '0) ? up_sum[FW-1:0] : f_stop;
    assign sweep_end = (Fword == f_stop) || (f_start >= f_stop);
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic [FW:0]   dn_diff;
    logic [FW-1:0] dn_word;
    assign dn_diff = {1'b0, Fword} - {1'b0, f_step};
    assign dn_word = (!dn_diff[FW] && dn_diff[FW-1:0] > f_start && f_step != '0) ? dn_diff[FW-1:0] : f_start;
`endif

    always_comb begin
        state_nxt = state;
        fword_nxt = Fword;
        pword_nxt = Pword;
        cnt_nxt   = cnt;
        stb_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (start && !abort) begin
                state_nxt = DWELL_UP;
                fword_nxt = f_start;
                pword_nxt = pword;
                cnt_nxt   = dwell;
                stb_nxt   = 1'b1;
            end
        end else if (abort) begin
            state_nxt = IDLE;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end else begin
            cnt_nxt = dwell;
            stb_nxt = 1'b1;
            if (state == DWELL_UP) begin
                if (!sweep_end) begin
                    fword_nxt = up_word;
                end else if (!cont) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    stb_nxt   = 1'b0;
                end
`ifdef DDS_SWEEP_TRIANGLE_EN
                else if (f_start < f_stop) begin
                    state_nxt = DWELL_DN;
                    fword_nxt = dn_word;
                end
`endif
                else begin
                    fword_nxt = f_start;
                end
            end
`ifdef DDS_SWEEP_TRIANGLE_EN
            else if (Fword == f_start) begin
                state_nxt = DWELL_UP;
                fword_nxt = up_word;
            end else begin
                fword_nxt = dn_word;
            end
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Fword     <= '0;
            Pword     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            step_stb  <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            f_start   <= '0;
            f_stop    <= '0;
            f_step    <= '0;
            dwell     <= '0;
            pword     <= '0;
            cont      <= 1'b0;
        end else begin
            state     <= state_nxt;
            Fword     <= fword_nxt;
            Pword     <= pword_nxt;
            cnt       <= cnt_nxt;
            busy      <= state_nxt != IDLE;
            step_stb  <= stb_nxt;
            done      <= done_nxt;
            cfg_ready <= state_nxt == IDLE;
            if (cfg_valid && cfg_ready) begin
                f_start <= cfg_f_start;
                f_stop  <= cfg_f_stop;
                f_step  <= cfg_f_step;
                dwell   <= cfg_dwell;
                pword   <= cfg_pword;
                cont    <= cfg_cont;
            end
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed checks of dds_sweep_ctrl sweeps, saturation, abort and reset.
module tb_dds_sweep_ctrl;
    logic        sys_clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, cfg_ready;
    logic [31:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0, Fword;
    logic [15:0] cfg_dwell = '0;
    logic [11:0] cfg_pword = '0, Pword;
    logic        cfg_cont = 1'b0, start = 1'b0, abort = 1'b0, busy, step_stb, done;
    int checks = 0, errors = 0, stb_cnt = 0;

    dds_sweep_ctrl dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_pword(cfg_pword), .cfg_cont(cfg_cont), .start(start),
        .abort(abort), .Fword(Fword), .Pword(Pword), .busy(busy), .step_stb(step_stb), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic [11:0] pw, input logic c);
        cfg_f_start = s; cfg_f_stop = e; cfg_f_step = st;
        cfg_dwell = dw; cfg_pword = pw; cfg_cont = c;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [31:0] e2 [5] = '{32'd100, 32'd200, 32'd300, 32'd350, 32'd350};
    logic [31:0] e3 [3] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic [31:0] e5 [8] = '{32'd0, 32'd100, 32'd200, 32'd300, 32'd200, 32'd100, 32'd0, 32'd100};
`else
    logic [31:0] e5 [8] = '{32'd0, 32'd100, 32'd200, 32'd300, 32'd0, 32'd100, 32'd200, 32'd300};
`endif

    initial begin
        step();
        chk("rst_fword", Fword, 0);
        chk("rst_pword", {20'd0, Pword}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stb", step_stb, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cfg_ready, 1);
        rst_n = 1'b1;
        // Unconfigured start: single one-cycle step at zero, then done.
        launch();
        chk("zero_fword", Fword, 0);
        chk("zero_busy", busy, 1);
        chk("zero_stb", step_stb, 1);
        step();
        chk("zero_done", done, 1);
        chk("zero_busy_end", busy, 0);
        step();
        chk("zero_done_once", done, 0);

        set_cfg(100, 400, 100, 2, 12'h5A5, 1'b0);
        launch();
        for (int i = 0; i < 14; i++) begin
            chk("t1_fword", Fword, i < 12 ? 100 * (i / 3 + 1) : 400);
            chk("t1_stb", step_stb, 32'(i < 12 && i % 3 == 0));
            chk("t1_done", done, 32'(i == 12));
            chk("t1_busy", busy, 32'(i < 12));
            stb_cnt += int'(step_stb);
            cfg_valid = (i == 1);
            cfg_f_stop = 150;
            step();
        end
        cfg_valid = 1'b0;
        chk("t1_stb_count", stb_cnt, 4);
        chk("t1_pword", {20'd0, Pword}, 32'h5A5);
        chk("t1_ready", cfg_ready, 1);

        set_cfg(100, 350, 100, 0, 0, 1'b0);
        launch();
        for (int i = 0; i < 5; i++) begin
            chk("t2_fword", Fword, e2[i]);
            chk("t2_stb", step_stb, 32'(i < 4));
            chk("t2_done", done, 32'(i == 4));
            step();
        end

        set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 0, 1'b0);
        launch();
        for (int i = 0; i < 3; i++) begin
            chk("t3_fword", Fword, e3[i]);
            chk("t3_done", done, 32'(i == 2));
            step();
        end

        set_cfg(100, 400, 100, 2, 0, 1'b0);
        launch();
        for (int i = 0; i < 5; i++) begin
            chk("t4_fword", Fword, i < 3 ? 100 : 200);
            if (i == 1) chk("t4_ready_busy", cfg_ready, 0);
            if (i < 4) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_fword", Fword, 200);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_stb", step_stb, 0);
        chk("t4_abort_ready", cfg_ready, 1);
        step();
        chk("t4_abort_done2", done, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t4_sa_busy", busy, 0);
        chk("t4_sa_stb", step_stb, 0);
        chk("t4_sa_fword", Fword, 200);

        set_cfg(0, 300, 100, 0, 0, 1'b1);
        launch();
        for (int i = 0; i < 8; i++) begin
            chk("t5_fword", Fword, e5[i]);
            chk("t5_stb", step_stb, 1);
            chk("t5_busy", busy, 1);
            chk("t5_done", done, 0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);

        set_cfg(100, 400, 100, 2, 12'h0F0, 1'b0);
        launch();
        repeat (4) step();
        chk("t6_pre_fword", Fword, 200);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_fword", Fword, 0);
        chk("t6_rst_pword", {20'd0, Pword}, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_stb", step_stb, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_post_done", done, 0);
            step();
        end
        set_cfg(500, 500, 0, 0, 12'h003, 1'b0);
        launch();
        chk("t6_new_fword", Fword, 500);
        chk("t6_new_pword", {20'd0, Pword}, 3);
        chk("t6_new_busy", busy, 1);
        step();
        chk("t6_new_done", done, 1);
        chk("t6_new_hold", Fword, 500);
        chk("t6_new_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
